powlib_fifo_rdctl: RTL and testbench
====================================

// Module: powlib_fifo_rdctl
// PURPOSE
//  Read-side controller for a FIFO built on powlib_dpram. It is the consumer end of a writer that
//  advances a Gray-coded write pointer. Decodes that pointer, tracks the read pointer and drives the
//  DPRAM read index. Presents data through a registered valid/ready output stage at one word per clock.
//  Returns its own Gray-coded read pointer to the writer for full detection.
// PARAMETERS
//  W     16             data width
//  D     8              FIFO depth in words; power of 2, >= 2
//  WIDX  clogb2(D)      DPRAM index width; pointers are WIDX+1 bits
// PORTS
//  clk         in   1        clock; all logic on posedge clk
//  rst         in   1        reset; synchronous, active-high
//  wrptr_gray  in   WIDX+1   writer pointer, Gray coded, already in the clk domain
//  rdptr_gray  out  WIDX+1   read pointer, Gray coded, registered
//  rdidx       out  WIDX     DPRAM read index = rdptr_bin[WIDX-1:0]
//  memdata     in   W        DPRAM rddata (combinational read of rdidx)
//  rddata      out  W        output word, registered
//  rdvld       out  1        rddata valid
//  rdrdy       in   1        consumer ready; transfer when rdvld && rdrdy at posedge
//  empty       out  1        memory empty: wrptr_bin == rdptr_bin (combinational)
//  cnt         out  WIDX+1   words in memory = wrptr_bin - rdptr_bin mod 2^(WIDX+1); excludes output reg
//  err         out  1        sticky pointer-consistency error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: rdptr_bin=0, rdptr_gray=0, rdvld=0, rddata=0, err=0. rdidx=0 follows from rdptr_bin=0.
//  - wrptr_bin = graydecode(wrptr_gray), combinational.
//  - ld = !empty && (!rdvld || rdrdy).
//    On ld: rddata<=memdata; rdvld<=1; rdptr_bin<=rdptr_bin+1; rdptr_gray<=grayencode(rdptr_bin+1).
//  - Else if rdvld && rdrdy: rdvld<=0, rddata holds its value.
//  - Else: all registers hold. rddata and rdvld never change while rdvld && !rdrdy (stall-stable).
//  - Latency: wrptr_gray first differs from rdptr_gray at edge N; rdvld=1 after edge N+1.
//  - Throughput: rdvld && rdrdy && !empty reloads in the same edge. No bubble; 1 word/clk sustained.
//  - Wrap: pointers count mod 2^(WIDX+1). rdidx wraps D-1 -> 0. The MSB toggle distinguishes full from
//    empty at the writer.
//  - rdptr_gray is a single register, never recomputed combinationally. Exactly one bit changes per
//    increment.
//  - rst mid-transfer: the held word is discarded and rdvld=0 on the next cycle. The writer must be
//    reset in the same cycle.
//  - rdrdy while rdvld=0 is ignored. A change on wrptr_gray during rst is ignored.
// CONFIGURATION
//  POWLIB_FIFO_RDCTL_CHK_EN defined:
//    - err is set (sticky until rst) when cnt > D, or when wrptr_gray changes by more than one bit in
//      one cycle. This needs one extra WIDX+1 register for the previous wrptr_gray.
//    - Each error event also issues $display("POWLIB_FIFO_RDCTL err ...") in simulation.
//  Not defined: err is tied 0, with no extra registers and no display.
//  Data-path behaviour is identical in both builds.
// TESTING
//  1 reset: rst=1 for 2 clk with wrptr_gray=0 -> rdvld=0, rddata=0, empty=1, cnt=0, rdptr_gray=0, err=0.
//  2 single word: mem[0]=16'hA5A5, wrptr_gray 0->1 at edge N, rdrdy=1
//    -> rdvld=1, rddata=A5A5 after N+1; rdptr_gray=1; rdvld=0 after N+2.
//  3 stall: D=8, writer fills 8 words (cnt=8), rdrdy=0 for 10 clk
//    -> first word held, rdvld=1, cnt=7, rddata stable; rdrdy=1 -> 8 words in order, one per clk.
//  4 wrap: 20 words streamed with rdrdy=1 and a writer that keeps 1-3 words ahead
//    -> in-order data, rdidx 7->0 wrap, rdptr_gray sequence single-bit steps, ends at grayencode(20 mod 16).
//  5 reset mid-op: rst=1 while rdvld=1, cnt=3 (writer also reset) -> next cycle rdvld=0, cnt=0, data dropped.
//  6 CHK_EN: wrptr_gray jumps 0->3 in one cycle -> err=1 next cycle, stays 1 until rst; without macro err=0.

Source files
------------

// File: rtl/powlib_fifo_rdctl.sv
// Read-side FIFO controller: decodes the writer's Gray pointer, drives the DPRAM read index and
// presents words through a registered valid/ready stage. Optional checker: POWLIB_FIFO_RDCTL_CHK_EN.
module powlib_fifo_rdctl #(
   parameter int W    = 16,
   parameter int D    = 8,
   parameter int WIDX = $clog2(D)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [WIDX:0]   wrptr_gray,
   output logic [WIDX:0]   rdptr_gray,
   output logic [WIDX-1:0] rdidx,
   input  logic [W-1:0]    memdata,
   output logic [W-1:0]    rddata,
   output logic            rdvld,
   input  logic            rdrdy,
   output logic            empty,
   output logic [WIDX:0]   cnt,
   output logic            err
);

   logic [WIDX:0]  wrptr_bin;
   logic [WIDX:0]  rdptr_bin_q, rdptr_bin_d;
   logic [WIDX:0]  rdptr_gray_q, rdptr_gray_d;
   logic [W-1:0]   rddata_q, rddata_d;
   logic           rdvld_q, rdvld_d;
   logic           ld;
   logic           empty_c;
   logic [WIDX:0]  cnt_c;

   // Binary value is the XOR of every right shift of the Gray code.
   function automatic logic [WIDX:0] gray2bin(input logic [WIDX:0] g);
      logic [WIDX:0] b;
      b = '0;
      for (int unsigned i = 0; i <= WIDX; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

   function automatic logic [WIDX:0] bin2gray(input logic [WIDX:0] b);
      return b ^ (b >> 1);
   endfunction

   always_comb begin
      wrptr_bin = gray2bin(wrptr_gray);
      empty_c   = (wrptr_bin == rdptr_bin_q);
      cnt_c     = wrptr_bin - rdptr_bin_q;
   end

   always_comb begin
      rdptr_bin_d  = rdptr_bin_q;
      rdptr_gray_d = rdptr_gray_q;
      rddata_d     = rddata_q;
      rdvld_d      = rdvld_q;
      ld           = !empty_c && (!rdvld_q || rdrdy);
      if (ld) begin
         rddata_d     = memdata;
         rdvld_d      = 1'b1;
         rdptr_bin_d  = rdptr_bin_q + 1'b1;
         rdptr_gray_d = bin2gray(rdptr_bin_q + 1'b1);
      end else if (rdvld_q && rdrdy) begin
         rdvld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdptr_bin_q  <= '0;
         rdptr_gray_q <= '0;
         rddata_q     <= '0;
         rdvld_q      <= 1'b0;
      end else begin
         rdptr_bin_q  <= rdptr_bin_d;
         rdptr_gray_q <= rdptr_gray_d;
         rddata_q     <= rddata_d;
         rdvld_q      <= rdvld_d;
      end
   end

   assign rdptr_gray = rdptr_gray_q;
   assign rdidx      = rdptr_bin_q[WIDX-1:0];
   assign rddata     = rddata_q;
   assign rdvld      = rdvld_q;
   assign empty      = empty_c;
   assign cnt        = cnt_c;

`ifdef POWLIB_FIFO_RDCTL_CHK_EN
   logic [WIDX:0] wrptr_prev_q;
   logic [WIDX:0] wrdelta;
   logic          err_q;
   logic          cnt_bad;
   logic          step_bad;

   // More than one bit set in the delta means a multi-bit Gray step.
   always_comb begin
      wrdelta  = wrptr_gray ^ wrptr_prev_q;
      cnt_bad  = (cnt_c > (WIDX+1)'(D));
      step_bad = ((wrdelta & (wrdelta - (WIDX+1)'(1))) != '0);
   end

   always_ff @(posedge clk) begin
      wrptr_prev_q <= wrptr_gray;
      if (rst) begin
         err_q <= 1'b0;
      end else if (cnt_bad || step_bad) begin
         err_q <= 1'b1;
`ifndef SYNTHESIS
         $display("POWLIB_FIFO_RDCTL err cnt=%0d wrptr_gray=%0h prev=%0h", cnt_c, wrptr_gray,
                  wrptr_prev_q);
`endif
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_powlib_fifo_rdctl.sv
// Self-checking bench for powlib_fifo_rdctl: bench-side DPRAM and writer model, scoreboard of
// written words compared at each output transfer. Honours POWLIB_FIFO_RDCTL_CHK_EN for err.
module tb_powlib_fifo_rdctl;

   localparam int W    = 16;
   localparam int D    = 8;
   localparam int WIDX = 3;

`ifdef POWLIB_FIFO_RDCTL_CHK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [WIDX:0]   wrptr_gray;
   logic [WIDX:0]   rdptr_gray;
   logic [WIDX-1:0] rdidx;
   logic [W-1:0]    memdata;
   logic [W-1:0]    rddata;
   logic            rdvld;
   logic            rdrdy;
   logic            empty;
   logic [WIDX:0]   cnt;
   logic            err;

   logic [W-1:0]    mem [D];
   logic [WIDX:0]   wrbin;
   logic [W-1:0]    sb[$];
   int              n_cmp = 0;
   int              n_err = 0;
   int              n_xfer = 0;

   always #5 clk = ~clk;

   assign memdata = mem[rdidx];

   powlib_fifo_rdctl #(.W(W), .D(D), .WIDX(WIDX)) dut (
      .clk        (clk),
      .rst        (rst),
      .wrptr_gray (wrptr_gray),
      .rdptr_gray (rdptr_gray),
      .rdidx      (rdidx),
      .memdata    (memdata),
      .rddata     (rddata),
      .rdvld      (rdvld),
      .rdrdy      (rdrdy),
      .empty      (empty),
      .cnt        (cnt),
      .err        (err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDX:0] g2b(input logic [WIDX:0] g);
      logic [WIDX:0] b;
      b[WIDX] = g[WIDX];
      for (int i = WIDX - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic write_word(input logic [W-1:0] data);
      mem[wrbin[WIDX-1:0]] = data;
      sb.push_back(data);
      wrbin      = wrbin + 1'b1;
      wrptr_gray = wrbin ^ (wrbin >> 1);
   endtask

   task automatic writer_reset();
      wrbin      = '0;
      wrptr_gray = '0;
      sb.delete();
   endtask

   // Output monitor: scoreboard compare on transfer, stall stability, single-bit read pointer steps.
   logic          prev_rst = 1'b1;
   logic          prev_stall = 1'b0;
   logic [W-1:0]  prev_data = '0;
   logic [WIDX:0] prev_gray = '0;
   always @(negedge clk) begin
      logic [W-1:0] exp;
      if (!rst && !prev_rst) begin
         if (prev_stall) begin
            chk("stall_vld", 32'(rdvld), 32'd1);
            chk("stall_data", 32'(rddata), 32'(prev_data));
         end
         if (rdptr_gray != prev_gray)
            chk("gray_step", 32'($countones(rdptr_gray ^ prev_gray)), 32'd1);
      end
      if (!rst && rdvld && rdrdy) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
         end else begin
            exp = sb.pop_front();
            chk("rddata", 32'(rddata), 32'(exp));
            n_xfer++;
         end
      end
      prev_stall = !rst && rdvld && !rdrdy;
      prev_data  = rddata;
      prev_gray  = rdptr_gray;
      prev_rst   = rst;
   end

   initial begin
      logic [W-1:0]  first;
      logic [WIDX:0] ahead;
      int            written;
      int            budget;
      bit            done;

      foreach (mem[i]) mem[i] = '0;
      rst   = 1'b1;
      rdrdy = 1'b0;
      writer_reset();

      // Reset
      tick();
      tick();
      chk("rst_rdvld", 32'(rdvld), 32'd0);
      chk("rst_rddata", 32'(rddata), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_rdptr_gray", 32'(rdptr_gray), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      tick();

      // Single word
      rdrdy = 1'b1;
      write_word(16'hA5A5);
      tick();
      chk("single_rdvld", 32'(rdvld), 32'd1);
      chk("single_rddata", 32'(rddata), 32'hA5A5);
      chk("single_rdptr_gray", 32'(rdptr_gray), 32'd1);
      tick();
      chk("single_drain", 32'(rdvld), 32'd0);
      chk("single_empty", 32'(empty), 32'd1);

      // Stall with a full memory, then back-to-back drain
      rdrdy = 1'b0;
      for (int i = 0; i < D; i++) begin
         write_word(16'h1000 + 16'(i));
         tick();
      end
      first = 16'h1000;
      chk("stall_rdvld", 32'(rdvld), 32'd1);
      chk("stall_cnt", 32'(cnt), 32'd7);
      chk("stall_first", 32'(rddata), 32'(first));
      repeat (10) tick();
      chk("stall_hold", 32'(rddata), 32'(first));
      n_xfer = 0;
      rdrdy  = 1'b1;
      repeat (D) tick();
      chk("drain_xfers", 32'(n_xfer), 32'(D));
      chk("drain_sb_empty", 32'(sb.size()), 32'd0);
      chk("drain_rdvld", 32'(rdvld), 32'd0);

      // Wrap: 20 words streamed from a fresh reset, writer 1-3 words ahead
      rst = 1'b1;
      rdrdy = 1'b0;
      writer_reset();
      tick();
      tick();
      rst = 1'b0;
      tick();
      rdrdy   = 1'b1;
      n_xfer  = 0;
      written = 0;
      done    = 1'b0;
      budget  = 0;
      while (!done && budget < 300) begin
         ahead = wrbin - g2b(rdptr_gray);
         if (written < 20 && int'(ahead) < int'($urandom_range(1, 3))) begin
            write_word(16'h2000 + 16'(written * 7));
            written++;
         end
         tick();
         budget++;
         done = (written == 20) && (sb.size() == 0) && !rdvld;
      end
      chk("wrap_done", 32'(done), 32'd1);
      chk("wrap_xfers", 32'(n_xfer), 32'd20);
      chk("wrap_rdptr_gray", 32'(rdptr_gray), 32'd6);
      chk("wrap_rdidx", 32'(rdidx), 32'd4);

      // Reset while a word is held
      rdrdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         write_word(16'h3000 + 16'(i));
         tick();
      end
      chk("midrst_rdvld_pre", 32'(rdvld), 32'd1);
      chk("midrst_cnt_pre", 32'(cnt), 32'd3);
      rst = 1'b1;
      writer_reset();
      tick();
      chk("midrst_rdvld", 32'(rdvld), 32'd0);
      chk("midrst_cnt", 32'(cnt), 32'd0);
      chk("midrst_rddata", 32'(rddata), 32'd0);
      chk("midrst_rdptr_gray", 32'(rdptr_gray), 32'd0);
      rst = 1'b0;
      tick();

      // Pointer-consistency checker: two-bit jump on the write pointer
      chk("err_clean", 32'(err), 32'd0);
      wrbin      = 4'd2;
      wrptr_gray = 4'd3;
      tick();
      chk("err_set", 32'(err), 32'(EXP_ERR));
      repeat (3) tick();
      chk("err_sticky", 32'(err), 32'(EXP_ERR));
      rst = 1'b1;
      writer_reset();
      tick();
      chk("err_cleared", 32'(err), 32'd0);
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
